fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 8'h00: byte address loaded into the PC at reset.
REQ-002 Parameter END_PC, default 8'h50: byte address at which fetching stops (program end).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_addr  output  8  byte address to the instruction memory; the memory uses addr[7:2] and returns data combinationally.
REQ-006 imem_instr  input  32  instruction word returned for imem_addr in the same cycle.
REQ-007 out_valid  output  1  out_instr/out_pc hold a valid fetched entry.
REQ-008 out_ready  input  1  decode accepts the entry; transfer occurs when out_valid && out_ready.
REQ-009 out_instr  output  32  instruction at the FIFO head.
REQ-010 out_pc  output  8  byte address of out_instr.
REQ-011 redirect_valid  input  1  one-cycle branch/jump redirect request.
REQ-012 redirect_pc  input  8  redirect target; bits [1:0] are ignored (forced to 0).
REQ-013 halt_req  input  1  level request to stop fetching.
REQ-014 halted  output  1  high when state is HALT and the FIFO is empty.
REQ-015 done  output  1  high when state is DONE.

Function
REQ-016 The block SHALL hold an 8-bit PC, a 2-entry FIFO of {pc[7:0], instr[31:0]}, and a state register with states RUN, HALT and DONE.
REQ-017 imem_addr SHALL equal the PC at all times.
REQ-018 A fetch SHALL occur in a cycle when state==RUN, redirect_valid==0, PC!=END_PC, and (count<2 or a pop occurs in the same cycle).
REQ-019 On a fetch, {PC, imem_instr} SHALL be pushed at the FIFO tail and PC SHALL advance by 4, modulo 256 (8'hFC wraps to 8'h00).
REQ-020 When a pop and a push occur in the same cycle, count SHALL be unchanged and ordering SHALL be preserved.
REQ-021 out_valid SHALL equal (count!=0); out_instr and out_pc SHALL reflect the FIFO head combinationally from registers; the head SHALL NOT change while out_valid && !out_ready.
REQ-022 Fetch-to-out_valid latency SHALL be one cycle: an instruction fetched at edge N is visible at the output after edge N.
REQ-023 redirect_valid SHALL take priority over all other events: FIFO flushed (count=0, any same-cycle pop discarded), PC <= {redirect_pc[7:2],2'b00}, no push in that cycle.
REQ-024 Redirect in RUN or DONE SHALL set state to RUN, or HALT if halt_req==1; redirect in HALT SHALL keep HALT.
REQ-025 RUN -> HALT SHALL occur when halt_req==1 is sampled; no fetch occurs in that cycle; entries already in the FIFO remain poppable.
REQ-026 HALT -> RUN SHALL occur when halt_req==0 is sampled; fetching resumes on the following cycle from the retained PC.
REQ-027 RUN -> DONE SHALL occur when PC==END_PC and no redirect is present; DONE performs no fetches, drains the FIFO normally, and ignores halt_req.
REQ-028 Fetch at FIFO full without a pop SHALL be suppressed, and the PC SHALL hold.

Reset
REQ-029 While rst_n==0: PC=RESET_PC, count=0, read/write pointers=0, state=RUN; out_valid=0, out_instr=0, out_pc=0, halted=0, done=0 (done=1 if RESET_PC==END_PC after release).
REQ-030 Reset assertion mid-operation SHALL discard all FIFO contents immediately, without waiting for a clock edge.

Verification
REQ-031 Reset release, out_ready=1, memory preloaded with the 20-word test program -> out_pc 0x00,0x04,...,0x4C on consecutive cycles with matching words (0x00007033 first, 0x03002603 last), then done=1 with no further out_valid.
REQ-032 out_ready=0 for 5 cycles after reset -> count saturates at 2 (pc 0x00,0x04), PC holds at 0x08, head stays 0x00007033; then out_ready=1 -> stream continues 0x04,0x08 with no gap or duplicate.
REQ-033 Redirect to 0x22 while count==2 and out_ready=1 -> next out_pc=0x20 (instr 0x00510293), pre-redirect entries never appear.
REQ-034 halt_req=1 at PC=0x10 with out_ready=1 -> FIFO drains, halted=1, imem_addr stays 0x10; halt_req=0 -> next out_pc=0x10.
REQ-035 RESET_PC=8'hFC, END_PC=8'h08 -> out_pc sequence 0xFC,0x00,0x04, then done=1.
REQ-036 rst_n pulled low asynchronously mid-stream with count==2 -> out_valid=0 before the next clock edge; PC=RESET_PC after release.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: byte-addressed PC, 2-entry {pc, instr} output FIFO,
// and a RUN/HALT/DONE state machine with redirect, halt and program-end handling.
module fetch_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] END_PC   = 8'h50
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [7:0]  out_pc,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Handshake: an entry transfers on a cycle where out_valid && out_ready are both
  // high at the rising edge; the head is stable while out_valid && !out_ready.

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [7:0]  fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];

  logic pop;
  logic push;
  logic unused_redirect_lo;

  assign unused_redirect_lo = ^redirect_pc[1:0];

  assign pop = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    push     = 1'b0;
    if (redirect_valid) begin
      // Flush wins over everything, including a same-cycle pop.
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      pc_d     = {redirect_pc[7:2], 2'b00};
      state_d  = (state_q == ST_HALT || halt_req) ? ST_HALT : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else if (pc_q == END_PC) begin
            state_d = ST_DONE;
          end else begin
            push = (count_q != 2'd2) || pop;
          end
        end
        ST_HALT: begin
          if (!halt_req) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
      if (pop) rd_ptr_d = ~rd_ptr_q;
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
        pc_d     = pc_q + 8'd4;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= 8'h00;
        fifo_instr_q[i] <= 32'h0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) begin
        fifo_pc_q[wr_ptr_q]    <= pc_q;
        fifo_instr_q[wr_ptr_q] <= imem_instr;
      end
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = fifo_pc_q[rd_ptr_q];
  assign out_instr = fifo_instr_q[rd_ptr_q];
  assign halted    = (state_q == ST_HALT) && (count_q == 2'd0);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule
